branch_resolve_unit: RTL and testbench

Tracks every prediction the branch predictor makes at fetch until the instruction reaches ID, then checks it against the resolved outcome. It drives the predictor's update port (`update_en`, `branch_taken`, `resolved_pc`, `resolved_target`, `resolved_state`) and generates the fetch redirect/flush on a misprediction. It sits between the IF stage (producer of prediction records) and the ID-stage branch comparator (consumer). It also keeps branch and mispredict performance counters.

---
 rtl/bp_pkg.sv | 18 +
 rtl/pred_fifo.sv | 73 +++++++
 rtl/branch_resolve_unit.sv | 98 +++++++++
 tb/tb_branch_resolve_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Types shared between the branch predictor and the branch resolve unit.
package bp_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
        bp_state_t   pred_state;
    } pred_rec_t;

endpackage

// File: rtl/pred_fifo.sv
// Circular FIFO of prediction records with synchronous clear and misuse flags.
module pred_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    input  logic      push,
    input  pred_rec_t wdata,
    input  logic      pop,
    output pred_rec_t head,
    output logic      full,
    output logic      empty,
    output logic      overflow,
    output logic      underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    pred_rec_t       mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A pop frees the slot the same cycle, so push-while-full is accepted when paired with a pop.
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign overflow  = push & full & ~pop;
    assign underflow = pop & empty;

    assign head = mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_pop)  head_d = head_q + 1'b1;
            if (do_push) tail_d = tail_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[tail_q] <= wdata;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks fetch-time predictions against ID-stage outcomes; drives predictor update and redirect.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_push,
    input  logic [31:0]      if_pc,
    input  logic             if_pred_taken,
    input  logic [31:0]      if_pred_target,
    input  logic [1:0]       if_pred_state,
    input  logic             id_pop,
    input  logic             id_is_branch,
    input  logic             id_actual_taken,
    input  logic [31:0]      id_actual_target,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             update_en,
    output logic             branch_taken,
    output logic [31:0]      resolved_pc,
    output logic [31:0]      resolved_target,
    output logic [1:0]       resolved_state,
    output logic             full,
    output logic             empty,
    output logic             err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    pred_rec_t        wrec, head;
    logic             overflow, underflow;
    logic             resolve, mispredict;
    logic             upd_en_q, upd_taken_q, err_q;
    logic [31:0]      upd_pc_q, upd_target_q;
    bp_state_t        upd_state_q;
    logic [CNT_W-1:0] br_cnt_q, mp_cnt_q;

    assign wrec = '{pc: if_pc, pred_taken: if_pred_taken, pred_target: if_pred_target,
                    pred_state: bp_state_t'(if_pred_state)};

    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (redirect_valid),
        .push      (if_push),
        .wdata     (wrec),
        .pop       (id_pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    assign resolve    = id_pop & id_is_branch & ~empty;
    assign mispredict = resolve & ((head.pred_taken != id_actual_taken) |
                        (head.pred_taken & id_actual_taken & (head.pred_target != id_actual_target)));

    assign redirect_valid = mispredict;
    assign redirect_pc    = id_actual_taken ? id_actual_target : head.pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_en_q     <= 1'b0;
            upd_taken_q  <= 1'b0;
            upd_pc_q     <= '0;
            upd_target_q <= '0;
            upd_state_q  <= STRONG_NT;
            br_cnt_q     <= '0;
            mp_cnt_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            upd_en_q <= resolve;
            if (resolve) begin
                upd_taken_q  <= id_actual_taken;
                upd_pc_q     <= head.pc;
                upd_target_q <= id_actual_target;
                upd_state_q  <= head.pred_state;
                br_cnt_q     <= br_cnt_q + CNT_W'(1);
            end
            if (mispredict) mp_cnt_q <= mp_cnt_q + CNT_W'(1);
            if (overflow || underflow) err_q <= 1'b1;
        end
    end

    assign update_en       = upd_en_q;
    assign branch_taken    = upd_taken_q;
    assign resolved_pc     = upd_pc_q;
    assign resolved_target = upd_target_q;
    assign resolved_state  = upd_state_q;
    assign err             = err_q;
    assign branch_cnt      = br_cnt_q;
    assign mispredict_cnt  = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: queue model of in-flight records and expected updates.
module tb_branch_resolve_unit;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
        logic [1:0]  pst;
    } mrec_t;

    typedef struct {
        logic        bt;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [1:0]  st;
    } upd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_push, if_pred_taken;
    logic [31:0] if_pc, if_pred_target;
    logic [1:0]  if_pred_state;
    logic        id_pop, id_is_branch, id_actual_taken;
    logic [31:0] id_actual_target;
    logic        redirect_valid, update_en, branch_taken, full, empty, err;
    logic [31:0] redirect_pc, resolved_pc, resolved_target;
    logic [1:0]  resolved_state;
    logic [31:0] branch_cnt, mispredict_cnt;

    mrec_t       mq[$];
    upd_t        upd_q[$];
    logic        m_err;
    logic [31:0] m_br, m_mp;
    int          n_checks = 0;
    int          n_errors = 0;

    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_push(if_push), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .if_pred_target(if_pred_target), .if_pred_state(if_pred_state),
        .id_pop(id_pop), .id_is_branch(id_is_branch), .id_actual_taken(id_actual_taken),
        .id_actual_target(id_actual_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .update_en(update_en), .branch_taken(branch_taken), .resolved_pc(resolved_pc),
        .resolved_target(resolved_target), .resolved_state(resolved_state),
        .full(full), .empty(empty), .err(err),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_regs();
        upd_t u;
        check_val("update_en", update_en, upd_q.size() > 0);
        if (upd_q.size() > 0) begin
            u = upd_q.pop_front();
            check_val("branch_taken", branch_taken, u.bt);
            check_val("resolved_pc", resolved_pc, u.pc);
            check_val("resolved_target", resolved_target, u.tgt);
            check_val("resolved_state", resolved_state, u.st);
        end
        check_val("empty", empty, mq.size() == 0);
        check_val("full", full, mq.size() == DEPTH);
        check_val("err", err, m_err);
        check_val("branch_cnt", branch_cnt, m_br);
        check_val("mispredict_cnt", mispredict_cnt, m_mp);
    endtask

    // Called just after a rising edge: drive, check combinational redirect mid-cycle, then registered state.
    task automatic cycle(input bit push, input logic [31:0] pc, input bit pt, input logic [31:0] ptgt,
                         input logic [1:0] pst, input bit pop, input bit isbr, input bit at,
                         input logic [31:0] atgt);
        mrec_t h;
        bit    resolve, mis, do_pop;
        logic [31:0] epc;
        if_push = push; if_pc = pc; if_pred_taken = pt; if_pred_target = ptgt; if_pred_state = pst;
        id_pop = pop; id_is_branch = isbr; id_actual_taken = at; id_actual_target = atgt;
        @(negedge clk);
        resolve = pop && isbr && (mq.size() > 0);
        mis = 1'b0;
        epc = '0;
        if (resolve) begin
            h   = mq[0];
            mis = (h.pt != at) || (h.pt && at && (h.ptgt != atgt));
            epc = at ? atgt : h.pc + 32'd4;
            upd_q.push_back('{bt: at, pc: h.pc, tgt: atgt, st: h.pst});
            m_br++;
            if (mis) m_mp++;
        end
        check_val("redirect_valid", redirect_valid, mis);
        if (mis) check_val("redirect_pc", redirect_pc, epc);
        if (mis) begin
            mq.delete();
        end else begin
            do_pop = pop && (mq.size() > 0);
            if (pop && mq.size() == 0) m_err = 1'b1;
            if (push && mq.size() == DEPTH && !do_pop) m_err = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (push && mq.size() < DEPTH) mq.push_back('{pc: pc, pt: pt, ptgt: ptgt, pst: pst});
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic push_rec(input logic [31:0] pc, input bit pt, input logic [31:0] ptgt,
                            input logic [1:0] pst);
        cycle(1, pc, pt, ptgt, pst, 0, 0, 0, 32'h0);
    endtask

    task automatic idle();
        cycle(0, 32'h0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        if_push = 0; if_pc = '0; if_pred_taken = 0; if_pred_target = '0; if_pred_state = '0;
        id_pop = 0; id_is_branch = 0; id_actual_taken = 0; id_actual_target = '0;
        m_err = 0; m_br = '0; m_mp = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_regs();
        idle();

        // Correctly predicted not-taken branch
        push_rec(32'h100, 0, 32'h0, 2'b00);
        cycle(0, 32'h0, 0, 32'h0, 2'b00, 1, 1, 0, 32'h0);
        idle();

        // Taken with wrong target
        push_rec(32'h200, 1, 32'h240, 2'b10);
        cycle(0, 32'h0, 0, 32'h0, 2'b00, 1, 1, 1, 32'h280);
        idle();

        // Predicted taken, resolves not-taken while a wrong-path push arrives
        push_rec(32'h300, 1, 32'h340, 2'b11);
        push_rec(32'h304, 0, 32'h0, 2'b01);
        cycle(1, 32'h308, 0, 32'h0, 2'b00, 1, 1, 0, 32'h344);
        idle();

        // Fill, push+pop while full, then overflow
        for (int i = 0; i < DEPTH; i++) push_rec(32'h400 + 32'(i * 4), 0, 32'h0, 2'(i));
        cycle(1, 32'h410, 0, 32'h0, 2'b01, 1, 0, 0, 32'h0);
        cycle(1, 32'h414, 0, 32'h0, 2'b10, 0, 0, 0, 32'h0);
        cycle(0, 32'h0, 0, 32'h0, 2'b00, 1, 1, 0, 32'h0);
        cycle(0, 32'h0, 0, 32'h0, 2'b00, 1, 0, 0, 32'h0);

        // Non-branch pop of a predicted-taken record never redirects
        push_rec(32'h500, 1, 32'h600, 2'b11);
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 0, 32'h0, 2'b00, 1, 0, 0, 32'h0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] rpc, rtgt;
            bit rpt, rat;
            rpc  = $urandom & 32'hFFFF_FFFC;
            rtgt = $urandom & 32'hFFFF_FFFC;
            rpt  = $urandom_range(0, 1) == 1;
            rat  = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0].pt : ($urandom_range(0, 1) == 1);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) rtgt = mq[0].ptgt;
            cycle($urandom_range(0, 2) != 0, rpc, rpt, rtgt, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, rat, rtgt);
        end
        for (int i = 0; i < 6; i++) cycle(0, 32'h0, 0, 32'h0, 2'b00, 1, 1, 0, 32'h0);

        // Mid-stream reset with three entries and a pending resolution
        idle();
        for (int i = 0; i < 3; i++) push_rec(32'h700 + 32'(i * 4), 0, 32'h0, 2'b01);
        if_push = 0; id_pop = 1; id_is_branch = 1; id_actual_taken = 0; id_actual_target = '0;
        #2 rst = 1'b1;
        #1;
        mq.delete(); upd_q.delete(); m_err = 0; m_br = '0; m_mp = '0;
        check_val("rst_empty", empty, 1'b1);
        check_val("rst_redirect", redirect_valid, 1'b0);
        @(posedge clk);
        #1;
        check_regs();
        rst = 1'b0;
        idle();

        // Pop on empty queue
        cycle(0, 32'h0, 0, 32'h0, 2'b00, 1, 1, 1, 32'h999);
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
